shift_sequencer: RTL
====================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameters: none; the data width SHALL be fixed at 16 bits and the amount width at 4 bits.
REQ-002 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  request present.
REQ-005 in_ready  out  1  block can accept a request.
REQ-006 in_data  in  16  operand.
REQ-007 in_amt  in  4  shift amount, 0-15.
REQ-008 in_op  in  2  operation: 0 rotate left, 1 shift left logical, 2 shift right arithmetic, 3 shift right logical.
REQ-009 out_valid  out  1  result present.
REQ-010 out_ready  in  1  consumer takes the result.
REQ-011 out_data  out  16  result.
REQ-012 busy  out  1  high in any state other than IDLE.

Function
REQ-013 The block SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 in_ready SHALL be high only in IDLE; a request SHALL be accepted on an edge where in_valid && in_ready, which latches data, amt and op.
REQ-015 IDLE->SHIFT on accept: stage index set to 3 (default build).
REQ-016 SHIFT, default build: each edge SHALL shift by 2^k when amt bit k is 1, else pass; k steps 3,2,1,0.
REQ-017 After the k=0 edge the block SHALL move to DONE, so out_valid is high exactly 5 edges after the accept edge.
REQ-018 Shift semantics:
- Rotate: bits wrap from the msb to the lsb.
- Logical shifts: zero fill.
- Arithmetic right shift: fills with bit 15 of the value as it was at request time.
- Bits shifted past bit 15 or bit 0 are discarded.
REQ-019 amt = 0 SHALL return in_data unchanged for every op.
REQ-020 DONE: out_valid = 1, and out_data SHALL be held stable until out_valid && out_ready.
REQ-021 When out_valid && out_ready on an edge, the block SHALL go DONE->IDLE, and in_ready SHALL rise in the next cycle; there is no overlap between consecutive requests.
REQ-022 in_valid asserted outside IDLE SHALL be ignored, and in_* changes during SHIFT SHALL NOT affect the result.
REQ-023 out_data SHALL be 0 whenever out_valid = 0.

Reset
REQ-024 rst_n low SHALL immediately force the following, in any state including mid-SHIFT or DONE, and the in-flight operation SHALL be discarded:
- state IDLE;
- in_ready = 1;
- out_valid = 0, out_data = 0, busy = 0;
- internal registers = 0.
REQ-025 After rst_n rises, the first accept SHALL be possible on the first edge.

Configuration
REQ-026 Macro SHIFT_SEQ_ZERO_SKIP_EN, when defined:
- SHIFT SHALL visit only the set bits of amt, msb first.
- Latency from the accept edge to out_valid SHALL be popcount(amt)+1 edges.
- amt = 0 SHALL go directly IDLE->DONE, so out_valid is high after the accept edge.
REQ-027 Macro undefined: the fixed 4-step behaviour of REQ-015 to REQ-017 SHALL apply.
REQ-028 Results SHALL be identical in both builds; only the latency differs.

Structure
REQ-029 Shared package shift_seq_pkg SHALL hold:
- the op encoding constants of REQ-008;
- the state enum typedef;
- the data width and amount width constants.
REQ-030 One sub-module, shift_stage, SHALL perform a single 2^k shift for a given op and k; the block SHALL instantiate it once and reuse it on every SHIFT cycle.

Verification
REQ-031 A bench SHALL cover these scenarios:
- op=0, data=0x1234, amt=4 -> out_data=0x2341; out_valid 5 edges after accept in the default build, 2 with the macro.
- op=1, data=0x00FF, amt=9 -> 0xFE00; op=3, data=0x8000, amt=15 -> 0x0001.
- op=2, data=0x8000, amt=15 -> 0xFFFF; op=2, data=0x4000, amt=1 -> 0x2000.
- amt=0 with each op, data=0xA5A5 -> 0xA5A5; latency 5 edges (default) or 1 edge (macro).
- out_ready held low for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
- rst_n pulsed low during SHIFT -> outputs reset immediately; the next request 0x0001 op1 amt1 -> 0x0002.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer: widths, op encoding, FSM states,
// and a helper that finds the most significant set bit of a shift amount.
package shift_seq_pkg;

   localparam int DATA_W = 16;
   localparam int AMT_W  = 4;
   localparam int K_W    = 2;

   localparam logic [1:0] OP_ROL = 2'd0;  // rotate left
   localparam logic [1:0] OP_SLL = 2'd1;  // shift left logical
   localparam logic [1:0] OP_SRA = 2'd2;  // shift right arithmetic
   localparam logic [1:0] OP_SRL = 2'd3;  // shift right logical

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Index of the highest set bit of amt; 0 when amt is 0.
   function automatic logic [K_W-1:0] msb_index(input logic [AMT_W-1:0] amt);
      msb_index = '0;
      for (int i = 0; i < AMT_W; i++) begin
         if (amt[i]) msb_index = K_W'(i);
      end
   endfunction

endpackage

// File: rtl/shift_sequencer_stage.sv
// shift_stage: one combinational shift by 2^k for the selected op.
// The arithmetic fill bit comes in separately so it always reflects the
// operand's sign at request time.
module shift_stage
   import shift_seq_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   input  logic [1:0]        op,
   input  logic [K_W-1:0]    k,
   input  logic              sign,
   output logic [DATA_W-1:0] result
);

   logic [4:0]        sh;
   logic [DATA_W-1:0] fill_mask;

   assign sh        = 5'd1 << k;
   assign fill_mask = ~(16'hFFFF >> sh);

   // Select the shifted value for the requested operation.
   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      result = data;
      case (op)
         OP_ROL:  result = (data << sh) | (data >> (5'd16 - sh));
         OP_SLL:  result = data << sh;
         OP_SRA:  result = (data >> sh) | (sign ? fill_mask : '0);
         OP_SRL:  result = data >> sh;
         default: result = data;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle barrel shifter built from one reused 2^k stage.
// Default build steps k = 3,2,1,0 on every request (5-edge latency).
// Define SHIFT_SEQ_ZERO_SKIP_EN to visit only the set bits of the amount,
// msb first (popcount(amt)+1 edges; amt = 0 goes straight to DONE).
module shift_sequencer
   import shift_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [AMT_W-1:0]  in_amt,
   input  logic [1:0]        in_op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy
);

   state_t            state, state_nxt;
   logic [DATA_W-1:0] data_r;
   logic [AMT_W-1:0]  amt_r;
   logic [1:0]        op_r;
   logic              sign_r;
   logic [K_W-1:0]    k_r;
   logic [DATA_W-1:0] stage_out;
   logic [AMT_W-1:0]  amt_rem;
   logic              last_step;

   shift_stage u_stage (
      .data   (data_r),
      .op     (op_r),
      .k      (k_r),
      .sign   (sign_r),
      .result (stage_out)
   );

   // Remaining amount bits once the current stage is done, and end-of-shift detect.
   always_comb begin
      amt_rem = amt_r & ~(AMT_W'(1) << k_r);
`ifdef SHIFT_SEQ_ZERO_SKIP_EN
      last_step = (amt_rem == '0);
`else
      last_step = (k_r == '0);
`endif
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
`ifdef SHIFT_SEQ_ZERO_SKIP_EN
               state_nxt = (in_amt == '0) ? DONE : SHIFT;
`else
               state_nxt = SHIFT;
`endif
            end
         end
         SHIFT:   if (last_step) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode; the result is masked to zero whenever it is not valid.
   always_comb begin
      in_ready  = (state == IDLE);
      busy      = (state != IDLE);
      out_valid = (state == DONE);
      out_data  = out_valid ? data_r : '0;
   end

   // Operand capture on accept and one stage step per SHIFT cycle; held in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r <= '0;
         amt_r  <= '0;
         op_r   <= '0;
         sign_r <= 1'b0;
         k_r    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  data_r <= in_data;
                  amt_r  <= in_amt;
                  op_r   <= in_op;
                  sign_r <= in_data[DATA_W-1];
`ifdef SHIFT_SEQ_ZERO_SKIP_EN
                  k_r    <= msb_index(in_amt);
`else
                  k_r    <= K_W'(3);
`endif
               end
            end
            SHIFT: begin
`ifdef SHIFT_SEQ_ZERO_SKIP_EN
               data_r <= stage_out;
               amt_r  <= amt_rem;
               k_r    <= msb_index(amt_rem);
`else
               if (amt_r[k_r]) data_r <= stage_out;
               k_r <= k_r - 1'b1;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule
